// File: rtl/run_sequencer.sv
// Sequences one program run of the 9-bit-ISA core: entry select, held reset, counted RUN, freeze.
// Optional watchdog enabled by defining RUN_SEQ_WATCHDOG_EN.
module run_sequencer #(
  parameter int D          = 12,
  parameter int CNT_W      = 16,
  parameter int RST_CYCLES = 2,
  parameter int TIMEOUT    = 4096,
  parameter int PROG0_ADDR = 0,
  parameter int PROG1_ADDR = 256,
  parameter int PROG2_ADDR = 512
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic [1:0]       prog_sel,
  input  logic             core_done,
  output logic             core_reset,
  output logic             core_run,
  output logic [D-1:0]     start_addr,
  output logic             done,
  output logic             busy,
  output logic [CNT_W-1:0] cycle_count,
  output logic             timeout
);

  localparam int RC_W = (RST_CYCLES > 2) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RC_W-1:0] RC_LOAD = RC_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CORE_RST = 2'd1,
    RUN      = 2'd2,
    FINISH   = 2'd3
  } state_t;

  state_t          state_r;
  logic            req_d_r;
  logic [1:0]      sel_r;
  logic [RC_W-1:0] rst_cnt_r;
  logic            start_s;

  assign start_s    = req & ~req_d_r;
  assign core_reset = (state_r == IDLE) || (state_r == CORE_RST);
  assign core_run   = (state_r == RUN);
  assign busy       = (state_r == CORE_RST) || (state_r == RUN);

`ifdef RUN_SEQ_WATCHDOG_EN
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);
  logic timeout_r;
  assign timeout = timeout_r;
`else
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  assign timeout = 1'b0;
`endif

  // Entry address decode from the latched program select
  always_comb begin
    start_addr = D'(PROG0_ADDR);
    case (sel_r)
      2'd0:    start_addr = D'(PROG0_ADDR);
      2'd1:    start_addr = D'(PROG1_ADDR);
      2'd2:    start_addr = D'(PROG2_ADDR);
      default: start_addr = D'(PROG0_ADDR);
    endcase
  end

  // Start-edge detector register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_d_r <= 1'b0;
    end else begin
      req_d_r <= req;
    end
  end

  // Run sequencing FSM with registered done/count/timeout
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      sel_r       <= 2'd0;
      rst_cnt_r   <= {RC_W{1'b0}};
      done        <= 1'b0;
      cycle_count <= {CNT_W{1'b0}};
`ifdef RUN_SEQ_WATCHDOG_EN
      timeout_r   <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE, FINISH: begin
          // A fresh start is accepted from both idle states; FINISH otherwise holds results
          if (start_s) begin
            sel_r       <= prog_sel;
            cycle_count <= {CNT_W{1'b0}};
            rst_cnt_r   <= RC_LOAD;
            done        <= 1'b0;
            state_r     <= CORE_RST;
`ifdef RUN_SEQ_WATCHDOG_EN
            timeout_r   <= 1'b0;
`endif
          end else begin
            done <= (state_r == FINISH);
          end
        end
        CORE_RST: begin
          if (rst_cnt_r == {RC_W{1'b0}}) begin
            state_r <= RUN;
          end else begin
            rst_cnt_r <= rst_cnt_r - {{(RC_W-1){1'b0}}, 1'b1};
          end
        end
        RUN: begin
`ifdef RUN_SEQ_WATCHDOG_EN
          cycle_count <= cycle_count + CNT_ONE;
          // core_done takes priority over a coincident watchdog expiry
          if (core_done) begin
            timeout_r <= 1'b0;
            done      <= 1'b1;
            state_r   <= FINISH;
          end else if (cycle_count == WD_LAST) begin
            timeout_r <= 1'b1;
            done      <= 1'b1;
            state_r   <= FINISH;
          end
`else
          if (cycle_count != CNT_MAX) begin
            cycle_count <= cycle_count + CNT_ONE;
          end
          if (core_done) begin
            done    <= 1'b1;
            state_r <= FINISH;
          end
`endif
        end
        default: begin
          state_r <= IDLE;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_run_sequencer.sv
// Directed self-checking bench for run_sequencer (TIMEOUT overridden to 20).
module tb_run_sequencer;

  localparam int D     = 12;
  localparam int CNT_W = 16;

  logic             clk;
  logic             reset;
  logic             req;
  logic [1:0]       prog_sel;
  logic             core_done;
  logic             core_reset;
  logic             core_run;
  logic [D-1:0]     start_addr;
  logic             done;
  logic             busy;
  logic [CNT_W-1:0] cycle_count;
  logic             timeout;

  int n_cmp;
  int n_err;

  run_sequencer #(
    .D(D), .CNT_W(CNT_W), .RST_CYCLES(2), .TIMEOUT(20),
    .PROG0_ADDR(0), .PROG1_ADDR(256), .PROG2_ADDR(512)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .prog_sel(prog_sel),
    .core_done(core_done), .core_reset(core_reset), .core_run(core_run),
    .start_addr(start_addr), .done(done), .busy(busy),
    .cycle_count(cycle_count), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  task automatic check_idle_state(input string tag, input logic [31:0] exp_cnt);
    check({tag, ".core_reset"}, 32'(core_reset), 32'd1);
    check({tag, ".core_run"},   32'(core_run),   32'd0);
    check({tag, ".busy"},       32'(busy),       32'd0);
    check({tag, ".done"},       32'(done),       32'd0);
    check({tag, ".count"},      32'(cycle_count), exp_cnt);
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    reset     = 1'b0;
    req       = 1'b0;
    prog_sel  = 2'd0;
    core_done = 1'b0;

    // Reset held low for three cycles, then released with req low
    tick(3);
    check_idle_state("in_reset", 32'd0);
    reset = 1'b1;
    tick(1);
    check_idle_state("idle", 32'd0);
    check("idle.start_addr", 32'(start_addr), 32'd0);
    check("idle.timeout",    32'(timeout),    32'd0);

    // Program 1, core_done in RUN cycle 10
    prog_sel = 2'd1;
    req      = 1'b1;
    tick(1);
    prog_sel = 2'd3;
    check("p1.rst1.core_reset", 32'(core_reset), 32'd1);
    check("p1.rst1.busy",       32'(busy),       32'd1);
    check("p1.start_addr",      32'(start_addr), 32'd256);
    tick(1);
    check("p1.rst2.core_reset", 32'(core_reset), 32'd1);
    check("p1.rst2.core_run",   32'(core_run),   32'd0);
    tick(1);
    check("p1.run.core_reset", 32'(core_reset), 32'd0);
    check("p1.run.core_run",   32'(core_run),   32'd1);
    req = 1'b0;
    tick(4);
    req = 1'b1;
    tick(5);
    check("p1.count9",     32'(cycle_count), 32'd9);
    check("p1.still_run",  32'(core_run),    32'd1);
    check("p1.start_addr_held", 32'(start_addr), 32'd256);
    core_done = 1'b1;
    tick(1);
    core_done = 1'b0;
    check("p1.done",       32'(done),        32'd1);
    check("p1.count",      32'(cycle_count), 32'd10);
    check("p1.timeout",    32'(timeout),     32'd0);
    check("p1.fin.run",    32'(core_run),    32'd0);
    check("p1.fin.reset",  32'(core_reset),  32'd0);
    check("p1.fin.busy",   32'(busy),        32'd0);

    // req held high through FINISH must not restart
    tick(3);
    check("hold.done",  32'(done),        32'd1);
    check("hold.busy",  32'(busy),        32'd0);
    check("hold.count", 32'(cycle_count), 32'd10);

    // Reset pulled 5 cycles into a run of program 0
    req = 1'b0;
    tick(1);
    prog_sel = 2'd0;
    req      = 1'b1;
    tick(1);
    check("mid.restart.done", 32'(done), 32'd0);
    tick(2);
    tick(5);
    check("mid.count5", 32'(cycle_count), 32'd5);
    reset = 1'b0;
    #1;
    check_idle_state("mid.async", 32'd0);
    check("mid.start_addr", 32'(start_addr), 32'd0);
    tick(2);
    // Release with req still high: first edge is a start
    reset = 1'b1;
    tick(1);
    check("post.rst.busy",       32'(busy),       32'd1);
    check("post.rst.core_reset", 32'(core_reset), 32'd1);
    tick(2);
    check("post.run", 32'(core_run), 32'd1);
    core_done = 1'b1;
    tick(1);
    core_done = 1'b0;
    check("post.done",  32'(done),        32'd1);
    check("post.count", 32'(cycle_count), 32'd1);

    // New run on program 2 clears the count
    req = 1'b0;
    tick(1);
    prog_sel = 2'd2;
    req      = 1'b1;
    tick(1);
    check("p2.start_addr", 32'(start_addr),  32'd512);
    check("p2.count_clr",  32'(cycle_count), 32'd0);
    check("p2.done_drop",  32'(done),        32'd0);
    tick(2);
    check("p2.run", 32'(core_run), 32'd1);

`ifdef RUN_SEQ_WATCHDOG_EN
    tick(19);
    check("wd.pre.done",  32'(done),        32'd0);
    check("wd.pre.count", 32'(cycle_count), 32'd19);
    tick(1);
    check("wd.done",    32'(done),        32'd1);
    check("wd.count",   32'(cycle_count), 32'd20);
    check("wd.timeout", 32'(timeout),     32'd1);

    // core_done coincident with watchdog limit
    req = 1'b0;
    tick(1);
    prog_sel = 2'd0;
    req      = 1'b1;
    tick(1);
    check("tie.timeout_clr", 32'(timeout), 32'd0);
    tick(2);
    tick(19);
    core_done = 1'b1;
    tick(1);
    core_done = 1'b0;
    check("tie.done",    32'(done),        32'd1);
    check("tie.count",   32'(cycle_count), 32'd20);
    check("tie.timeout", 32'(timeout),     32'd0);
`else
    tick(65534);
    check("sat.pre.count", 32'(cycle_count), 32'd65534);
    tick(1);
    check("sat.count", 32'(cycle_count), 32'd65535);
    tick(3);
    check("sat.hold",    32'(cycle_count), 32'd65535);
    check("sat.done",    32'(done),        32'd0);
    check("sat.busy",    32'(busy),        32'd1);
    check("sat.timeout", 32'(timeout),     32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/run_sequencer.md
Name:
run_sequencer

Overview:
- Sequences one program execution of the 9-bit-ISA core between the test bench and the core's top level.
- On a bench start request it:
  - selects the program entry address;
  - holds the core in reset for a fixed number of cycles;
  - releases the core and counts execution cycles until the core reports halt or a watchdog expires;
  - then freezes the core and raises done.
- Sits between bench req/done and the core's reset, PC start address and run enable.

Parameters:
D, 12, PC / start-address width
CNT_W, 16, cycle counter width
RST_CYCLES, 2, cycles core_reset is held after a start (>=1)
TIMEOUT, 4096, watchdog limit in RUN cycles (>=2, < 2**CNT_W)
PROG0_ADDR, 0, entry address, program 0
PROG1_ADDR, 256, entry address, program 1
PROG2_ADDR, 512, entry address, program 2

Ports:
clk  input  1  single clock, rising edge
reset  input  1  asynchronous, active-low reset
req  input  1  bench start request, level; rising edge starts a run
prog_sel  input  2  program select, sampled on the start edge
core_done  input  1  core halt indication
core_reset  output  1  active-high reset to core (PC loads start_addr)
core_run  output  1  core clock enable; PC/regfile/mem update only when high
start_addr  output  D  entry address for the latched program
done  output  1  run finished; held until next start
busy  output  1  high in CORE_RST and RUN
cycle_count  output  CNT_W  RUN cycles of the last or current run
timeout  output  1  last run ended by watchdog

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, core_reset=1, core_run=0, done=0, busy=0.
  - cycle_count=0, timeout=0, sel_q=0, start_addr=PROG0_ADDR, req_q=0.
- Start detection:
  - req_q is req registered each cycle; start = req & ~req_q.
  - A level held high never restarts.
  - The first edge after reset release with req already high counts as a start.
- start_addr is decoded from registered sel_q: 0/1/2 -> PROG0/1/2_ADDR; 3 -> PROG0_ADDR.
- IDLE:
  - core_reset=1, core_run=0, done=0.
  - On start: latch sel_q=prog_sel, clear cycle_count and timeout, load rst_cnt=RST_CYCLES-1, go to CORE_RST.
- CORE_RST:
  - core_reset=1, core_run=0, busy=1.
  - Decrement rst_cnt; at 0 go to RUN. Exactly RST_CYCLES cycles are spent here.
- RUN:
  - core_reset=0, core_run=1, busy=1.
  - Each edge: cycle_count += 1, including the exit edge.
  - core_done=1: go to FINISH, timeout=0.
  - Otherwise, if cycle_count==TIMEOUT-1: go to FINISH, timeout=1 (cycle_count ends at TIMEOUT).
  - core_done and watchdog in the same cycle: core_done wins, timeout=0.
- FINISH:
  - done=1, core_run=0, core_reset=0 (core state preserved for bench inspection), busy=0.
  - cycle_count and timeout are held.
  - On start: same actions as in IDLE, go to CORE_RST directly, done drops the next cycle.
- Ignored inputs:
  - req edges in CORE_RST and RUN.
  - core_done outside RUN.
  - prog_sel except on the start edge.
- Reset mid-run: asynchronous return to IDLE with all reset values; the partial count is discarded.
- Latency:
  - start edge -> core_reset held RST_CYCLES cycles -> first core_run cycle.
  - core_done sampled high -> done=1 the next cycle.
- All outputs are registered except start_addr (decode of sel_q) and core_reset/core_run/busy (decodes of state).

Optional Feature:
RUN_SEQ_WATCHDOG_EN
- Defined: watchdog as above.
- Undefined:
  - No watchdog comparator; RUN exits only on core_done or reset.
  - timeout is tied 0.
  - cycle_count saturates at 2**CNT_W-1 instead of wrapping.

Test Plan:
- Reset low 3 cycles, release with req=0 -> IDLE, core_reset=1, done=0, cycle_count=0, start_addr=0.
- prog_sel=1, req rises, core_done asserted 10 cycles into RUN -> core_reset high exactly 2 cycles, start_addr=256, done=1 one cycle after core_done, cycle_count=10, timeout=0.
- TIMEOUT=20, core_done never asserted -> done after 20 RUN cycles, cycle_count=20, timeout=1. Same with macro undefined -> never done, cycle_count saturates at 65535 (CNT_W=16).
- core_done and watchdog limit in the same cycle (TIMEOUT=20, core_done in RUN cycle 20) -> timeout=0, cycle_count=20.
- req held high through FINISH -> no restart. req low then high with prog_sel=2 -> new run at start_addr=512, cycle_count cleared. req toggled during RUN -> ignored.
- reset pulled low 5 cycles into RUN -> immediate IDLE, core_run=0, cycle_count=0. Next start runs normally.
